csa_accum_seq: RTL and testbench



---
 rtl/csa_seq_pkg.sv | 10 +
 rtl/csa_3to2.sv | 21 ++
 rtl/csa_accum_seq.sv | 98 +++++++++
 tb/tb_csa_accum_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_seq_pkg.sv
// csa_seq_pkg: state type and accumulator width helper shared by csa_accum_seq.
package csa_seq_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUT} csa_seq_state_t;

   function automatic int acc_w(input int data_w, input int max_ops);
      return data_w + $clog2(max_ops);
   endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: combinational 3:2 carry-save compressor; carry is pre-shifted into its weight.
module csa_3to2 #(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] cin,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   logic [W-1:0] maj;

   // Bitwise sum and majority; the majority MSB falls off the shift.
   always_comb begin
      sum   = a ^ b ^ cin;
      maj   = (a & b) | (a & cin) | (b & cin);
      carry = {maj[W-2:0], 1'b0};
   end

endmodule

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: sequential multi-operand adder over one registered 3:2 CSA stage; CSA_SEQ_OVF_EN adds o_ovf.
module csa_accum_seq
   import csa_seq_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int MAX_OPS = 16,
   parameter int ACC_W   = acc_w(DATA_W, MAX_OPS),
   parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ACC_W-1:0]  o_sum,
   output logic [CNT_W-1:0]  o_cnt
`ifdef CSA_SEQ_OVF_EN
   ,
   output logic              o_ovf
`endif
);

   csa_seq_state_t state, state_n;
   logic [ACC_W-1:0] s, c, x, csa_s, csa_c;
   logic [CNT_W-1:0] cnt;
   logic acc, close;

   assign o_ready = (state == IDLE) || (state == ACCUM);
   assign o_valid = state == OUT;
   assign acc     = i_valid && o_ready;
   assign x       = ACC_W'(i_data);
   assign close   = i_last || (state == ACCUM && cnt == CNT_W'(MAX_OPS - 1));

   csa_3to2 #(.W(ACC_W)) u_csa (
      .a    (s),
      .b    (c),
      .cin  (x),
      .sum  (csa_s),
      .carry(csa_c)
   );

   // State register.
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   // Next state: a group closes on i_last or when the counter reaches MAX_OPS.
   always_comb begin
      state_n = state;
      case (state)
         IDLE, ACCUM: state_n = acc ? (close ? RESOLVE : ACCUM) : state;
         RESOLVE:     state_n = OUT;
         OUT:         state_n = i_ready ? IDLE : OUT;
         default:     state_n = IDLE;
      endcase
   end

   // Fold operands into the redundant pair, then resolve once into the output registers.
   always_ff @(posedge clk)
      if (rst) begin
         s     <= '0;
         c     <= '0;
         cnt   <= '0;
         o_sum <= '0;
         o_cnt <= '0;
      end else begin
         if (acc) begin
            s   <= state == IDLE ? x : csa_s;
            c   <= state == IDLE ? '0 : csa_c;
            cnt <= state == IDLE ? CNT_W'(1) : cnt + CNT_W'(1);
         end
         if (state == RESOLVE) begin
            o_sum <= s + c;
            o_cnt <= cnt;
         end
      end

`ifdef CSA_SEQ_OVF_EN
   logic last_q;

   // Flag groups that hit MAX_OPS without an i_last on the final operand.
   always_ff @(posedge clk)
      if (rst) begin
         last_q <= 1'b0;
         o_ovf  <= 1'b0;
      end else begin
         if (acc)
            last_q <= i_last;
         if (state == RESOLVE)
            o_ovf <= !last_q && cnt == CNT_W'(MAX_OPS);
         else if (state == OUT && i_ready)
            o_ovf <= 1'b0;
      end
`endif

endmodule

// File: tb/tb_csa_accum_seq.sv
// tb_csa_accum_seq: directed and randomized checks of csa_accum_seq against a running-sum model; honours CSA_SEQ_OVF_EN.
module tb_csa_accum_seq;

   localparam int ACC_W = 12, CNT_W = 5, MAX_OPS = 16;

   logic clk = 0, rst = 1, i_valid = 0, i_last = 0, i_ready = 0;
   logic [7:0] i_data = 0;
   logic o_ready, o_valid, o_ovf;
   logic [ACC_W-1:0] o_sum;
   logic [CNT_W-1:0] o_cnt;

   int checks = 0, errors = 0, hs = 0;
   int phase = 0, msum = 0, mcnt = 0, exp_sum = 0, exp_cnt = 0;
   logic exp_ovf = 0;

   always #5 clk = ~clk;

   csa_accum_seq dut (
      .clk    (clk),
      .rst    (rst),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_data (i_data),
      .i_last (i_last),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_sum  (o_sum),
      .o_cnt  (o_cnt)
`ifdef CSA_SEQ_OVF_EN
      ,
      .o_ovf  (o_ovf)
`endif
   );

`ifndef CSA_SEQ_OVF_EN
   assign o_ovf = 1'b0;
`endif

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: running integer sum per group; result visible one cycle after close, held until handshake.
   always @(negedge clk) begin
      if (!rst) begin
         check("ready", o_ready, phase == 0);
         check("valid", o_valid, phase == 2);
         if (phase == 2) begin
            check("sum", o_sum, exp_sum);
            check("cnt", o_cnt, exp_cnt);
`ifdef CSA_SEQ_OVF_EN
            check("ovf", o_ovf, exp_ovf);
`endif
         end
      end
      if (rst) begin
         phase = 0;
         msum  = 0;
         mcnt  = 0;
      end else if (phase == 0) begin
         if (i_valid) begin
            msum += i_data;
            mcnt++;
            if (i_last || mcnt == MAX_OPS) begin
               exp_sum = msum % (1 << ACC_W);
               exp_cnt = mcnt;
               exp_ovf = !i_last;
               msum    = 0;
               mcnt    = 0;
               phase   = 1;
            end
         end
      end else if (phase == 1) begin
         phase = 2;
      end else if (i_ready) begin
         phase = 0;
         hs++;
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      int t = 0;
      logic r;
      i_valid = 1;
      i_data  = d;
      i_last  = l;
      do begin
         r = o_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!r && t < 50);
      check("send_accept", r, 1);
      i_valid = 0;
      i_last  = 0;
   endtask

   task automatic get(input int hold, output logic [ACC_W-1:0] s, output logic [CNT_W-1:0] n,
                      output logic v);
      int t = 0;
      while (!o_valid && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("get_valid", o_valid, 1);
      repeat (hold) begin
         @(posedge clk);
         #1;
         check("hold_valid", o_valid, 1);
      end
      s = o_sum;
      n = o_cnt;
      v = o_ovf;
      i_ready = 1;
      @(posedge clk);
      #1;
      i_ready = 0;
      check("post_hs_valid", o_valid, 0);
      check("post_hs_ready", o_ready, 1);
   endtask

   initial begin
      logic [ACC_W-1:0] s;
      logic [CNT_W-1:0] n;
      logic v;
      int base, cyc;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      check("rst_sum", o_sum, 0);
      check("rst_cnt", o_cnt, 0);
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 1);

      send(3, 0);
      send(5, 0);
      send(7, 1);
      check("lat_resolve_ready", o_ready, 0);
      check("lat_resolve_valid", o_valid, 0);
      @(posedge clk);
      #1;
      check("lat_out_valid", o_valid, 1);
      check("lat_out_ready", o_ready, 0);
      get(0, s, n, v);
      check("g357_sum", s, 15);
      check("g357_cnt", n, 3);

      send(200, 1);
      get(0, s, n, v);
      check("single_sum", s, 200);
      check("single_cnt", n, 1);

      for (int i = 0; i < 16; i++) send(255, 0);
      get(0, s, n, v);
      check("force_sum", s, 4080);
      check("force_cnt", n, 16);
`ifdef CSA_SEQ_OVF_EN
      check("force_ovf", v, 1);
`endif
      send(1, 1);
      get(0, s, n, v);
      check("after_force_sum", s, 1);
      check("after_force_cnt", n, 1);
`ifdef CSA_SEQ_OVF_EN
      check("after_force_ovf", v, 0);
`endif

      send(1, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      send(2, 1);
      get(5, s, n, v);
      check("bubble_sum", s, 3);
      check("bubble_cnt", n, 2);

      send(10, 0);
      send(20, 0);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      check("midrst_valid", o_valid, 0);
      check("midrst_ready", o_ready, 1);
      send(4, 1);
      get(0, s, n, v);
      check("post_rst_sum", s, 4);
      check("post_rst_cnt", n, 1);

      base = hs;
      cyc  = 0;
      while (hs - base < 1000 && cyc < 60000) begin
         i_valid = $urandom_range(0, 3) != 0;
         i_data  = 8'($urandom);
         i_last  = $urandom_range(0, 5) == 0;
         i_ready = $urandom_range(0, 2) != 0;
         @(posedge clk);
         #1;
         cyc++;
      end
      i_valid = 0;
      i_last  = 0;
      i_ready = 0;
      check("random_groups", hs - base, 1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
